// File: rtl/vote_round_ctrl_if.sv
// Handshake and vote bus between the round controller and its environment.
// slave = controller side, master = driver side.
interface vote_round_ctrl_if;
  logic       start;
  logic       ack;
  logic [4:0] vote_valid;
  logic [4:0] vote_val;
  logic [4:0] comps;
  logic [4:0] cast;
  logic       busy;
  logic       done;
  logic [2:0] count;
  logic       majority;

  modport slave (
    input  start, ack, vote_valid, vote_val,
    output comps, cast, busy, done, count, majority
  );

  modport master (
    output start, ack, vote_valid, vote_val,
    input  comps, cast, busy, done, count, majority
  );
endinterface

// File: rtl/vote_round_ctrl.sv
// Five-voter round controller: opens a timed voting window, latches the first
// vote of each voter, and presents count/majority until acknowledged.

module vote_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_vld,
  input  logic i_val,
  output logic o_comp,
  output logic o_cast
);
  logic r_comp, r_cast;

  // First vote wins: once cast is set the slot ignores further strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp <= 1'b0;
      r_cast <= 1'b0;
    end else if (i_clr) begin
      r_comp <= 1'b0;
      r_cast <= 1'b0;
    end else if (i_en && i_vld && !r_cast) begin
      r_comp <= i_val;
      r_cast <= 1'b1;
    end
  end

  assign o_comp = r_comp;
  assign o_cast = r_cast;
endmodule

module vote_round_ctrl #(
  parameter int unsigned WINDOW = 1000
) (
  input logic               clk,
  input logic               rst_n,
  vote_round_ctrl_if.slave  bus
);
  localparam int NV = 5;
  localparam int TW = 16;

  typedef enum logic [1:0] {IDLE, OPEN, RESULT} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [NV-1:0] w_comps, w_cast, w_cast_nxt;
  logic          w_open, w_clr, w_all_cast;
  logic [2:0]    w_pop;

  assign w_open     = (r_state == OPEN);
  assign w_clr      = (r_state == RESULT) && bus.ack;
  // Cast bits as they will be after this edge, so the fifth voter closes early.
  assign w_cast_nxt = w_cast | (bus.vote_valid & {NV{w_open}});
  assign w_all_cast = &w_cast_nxt;

  for (genvar g = 0; g < NV; g++) begin : g_slot
    vote_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_open),
      .i_vld  (bus.vote_valid[g]),
      .i_val  (bus.vote_val[g]),
      .o_comp (w_comps[g]),
      .o_cast (w_cast[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= OPEN;
          r_timer <= TW'(WINDOW - 1);
        end
        OPEN: begin
          if (r_timer != '0) r_timer <= r_timer - 1'b1;
          if (w_all_cast || r_timer == '0) r_state <= RESULT;
        end
        RESULT: if (bus.ack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NV; i++) w_pop = w_pop + 3'(w_comps[i]);
  end

  assign bus.comps    = w_comps;
  assign bus.cast     = w_cast;
  assign bus.busy     = (r_state == OPEN);
  assign bus.done     = (r_state == RESULT);
  assign bus.count    = bus.done ? w_pop : 3'd0;
  assign bus.majority = bus.done && (w_pop >= 3'd3);
endmodule

// File: tb/tb_vote_round_ctrl.sv
// Table-driven bench with a one-deep scoreboard; two instances (WINDOW=8, WINDOW=4).
module tb_vote_round_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vote_round_ctrl_if ifa ();
  vote_round_ctrl_if ifb ();

  logic       sel;
  logic       st, ak;
  logic [4:0] vv, vl;

  assign ifa.start      = sel ? 1'b0 : st;
  assign ifa.ack        = sel ? 1'b0 : ak;
  assign ifa.vote_valid = sel ? 5'd0 : vv;
  assign ifa.vote_val   = sel ? 5'd0 : vl;
  assign ifb.start      = sel ? st : 1'b0;
  assign ifb.ack        = sel ? ak : 1'b0;
  assign ifb.vote_valid = sel ? vv : 5'd0;
  assign ifb.vote_val   = sel ? vl : 5'd0;

  vote_round_ctrl #(.WINDOW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  vote_round_ctrl #(.WINDOW(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  wire [4:0] o_comps = sel ? ifb.comps    : ifa.comps;
  wire [4:0] o_cast  = sel ? ifb.cast     : ifa.cast;
  wire       o_busy  = sel ? ifb.busy     : ifa.busy;
  wire       o_done  = sel ? ifb.done     : ifa.done;
  wire [2:0] o_cnt   = sel ? ifb.count    : ifa.count;
  wire       o_maj   = sel ? ifb.majority : ifa.majority;

  typedef struct {
    logic       sel, st, ak;
    logic [4:0] vv, vl, comps, cast;
    logic       busy, done;
    logic [2:0] cnt;
    logic       maj;
  } row_t;

  row_t tbl[$];
  row_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void add(logic s, logic st_, logic ak_, logic [4:0] vv_, logic [4:0] vl_,
                              logic [4:0] c, logic [4:0] k, logic b, logic d,
                              logic [2:0] n, logic m);
    row_t r;
    r.sel = s; r.st = st_; r.ak = ak_; r.vv = vv_; r.vl = vl_;
    r.comps = c; r.cast = k; r.busy = b; r.done = d; r.cnt = n; r.maj = m;
    tbl.push_back(r);
  endfunction

  task automatic check_outs(string tag, logic [4:0] c, logic [4:0] k, logic b, logic d,
                            logic [2:0] n, logic m);
    chk({tag, " comps"},    int'(o_comps), int'(c));
    chk({tag, " cast"},     int'(o_cast),  int'(k));
    chk({tag, " busy"},     int'(o_busy),  int'(b));
    chk({tag, " done"},     int'(o_done),  int'(d));
    chk({tag, " count"},    int'(o_cnt),   int'(n));
    chk({tag, " majority"}, int'(o_maj),   int'(m));
  endtask

  task automatic run_row(row_t r, string tag);
    row_t e;
    sel = r.sel; st = r.st; ak = r.ak; vv = r.vv; vl = r.vl;
    sbq.push_back(r);
    @(posedge clk); #1;
    e = sbq.pop_front();
    check_outs(tag, e.comps, e.cast, e.busy, e.done, e.cnt, e.maj);
  endtask

  initial begin
    row_t h;
    sel = 1'b0; st = 1'b0; ak = 1'b0; vv = '0; vl = '0;

    // two voting waves, early close, 5 ignored cycles of start, then ack
    add(0, 1,0, 5'b00000,5'b00000, 5'b00000,5'b00000, 1,0, 0,0);
    add(0, 0,0, 5'b00000,5'b00000, 5'b00000,5'b00000, 1,0, 0,0);
    add(0, 0,0, 5'b10101,5'b10101, 5'b10101,5'b10101, 1,0, 0,0);
    add(0, 0,0, 5'b01010,5'b00000, 5'b10101,5'b11111, 0,1, 3,1);
    for (int i = 0; i < 5; i++)
      add(0, 1,0, 5'b11111,5'b00000, 5'b10101,5'b11111, 0,1, 3,1);
    add(0, 1,1, 5'b00000,5'b00000, 5'b00000,5'b00000, 0,0, 0,0);
    // single voter, full timeout; start held during OPEN must not reload
    add(0, 1,0, 5'b00000,5'b00000, 5'b00000,5'b00000, 1,0, 0,0);
    add(0, 0,0, 5'b00010,5'b00010, 5'b00010,5'b00010, 1,0, 0,0);
    for (int i = 0; i < 6; i++)
      add(0, 1,0, 5'b00000,5'b00000, 5'b00010,5'b00010, 1,0, 0,0);
    add(0, 0,0, 5'b00000,5'b00000, 5'b00010,5'b00010, 0,1, 1,0);
    add(0, 0,1, 5'b00000,5'b00000, 5'b00000,5'b00000, 0,0, 0,0);
    // re-vote ignored
    add(0, 1,0, 5'b00000,5'b00000, 5'b00000,5'b00000, 1,0, 0,0);
    add(0, 0,0, 5'b01000,5'b01000, 5'b01000,5'b01000, 1,0, 0,0);
    add(0, 0,0, 5'b00000,5'b00000, 5'b01000,5'b01000, 1,0, 0,0);
    add(0, 0,0, 5'b01000,5'b00000, 5'b01000,5'b01000, 1,0, 0,0);
    for (int i = 0; i < 4; i++)
      add(0, 0,0, 5'b00000,5'b00000, 5'b01000,5'b01000, 1,0, 0,0);
    add(0, 0,0, 5'b00000,5'b00000, 5'b01000,5'b01000, 0,1, 1,0);
    add(0, 0,1, 5'b00000,5'b00000, 5'b00000,5'b00000, 0,0, 0,0);
    // WINDOW=4 instance: vote on the timeout edge is captured
    add(1, 1,0, 5'b00000,5'b00000, 5'b00000,5'b00000, 1,0, 0,0);
    for (int i = 0; i < 3; i++)
      add(1, 0,0, 5'b00000,5'b00000, 5'b00000,5'b00000, 1,0, 0,0);
    add(1, 0,0, 5'b00001,5'b00001, 5'b00001,5'b00001, 0,1, 1,0);
    add(1, 0,1, 5'b00000,5'b00000, 5'b00000,5'b00000, 0,0, 0,0);

    #12;
    check_outs("reset", 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("row%0d", i));

    // asynchronous reset mid-OPEN discards the round
    h = '{sel:0, st:1, ak:0, vv:0, vl:0, comps:0, cast:0, busy:1, done:0, cnt:0, maj:0};
    run_row(h, "rst_start");
    h = '{sel:0, st:0, ak:0, vv:5'b00111, vl:5'b00101, comps:5'b00101, cast:5'b00111,
          busy:1, done:0, cnt:0, maj:0};
    run_row(h, "rst_vote");
    vv = '0; vl = '0;
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    check_outs("rst_hold", 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    h = '{sel:0, st:1, ak:0, vv:0, vl:0, comps:0, cast:0, busy:1, done:0, cnt:0, maj:0};
    run_row(h, "fresh_start");
    h = '{sel:0, st:0, ak:0, vv:0, vl:0, comps:0, cast:0, busy:1, done:0, cnt:0, maj:0};
    run_row(h, "fresh_open");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
